// File: rtl/maze_tile_painter_pkg.sv
// Shared framebuffer geometry for the tile painter, the framebuffer RAM and the VGA reader.
// Also holds a constant-multiply helper that expands into shift-adds.
package maze_tile_painter_pkg;
  localparam int SCREEN_WIDTH  = 270;
  localparam int SCREEN_HEIGHT = 270;
  localparam int TILE_SIZE     = 30;
  localparam int GRID_DIM      = 9;
  localparam int PIX_W         = 4;
  localparam int ADDR_W        = 17;
  localparam int CNT_W         = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAINT = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // k is a constant at every call site, so only the set bits of k become adders
  function automatic logic [ADDR_W-1:0] cmul(input logic [3:0] a, input int unsigned k);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++)
      if (k[i]) acc = acc + (ADDR_W'(a) << i);
    return acc;
  endfunction
endpackage

// File: rtl/maze_tile_addr_gen.sv
// Raster-scan x/y counters with an incrementally stepped framebuffer address.
// Serves both tile painting and full-screen clear.
module maze_tile_addr_gen
  import maze_tile_painter_pkg::*;
#(
  parameter int STRIDE = SCREEN_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  width,
  input  logic [CNT_W-1:0]  height,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  x,
  output logic [CNT_W-1:0]  y,
  output logic              last
);
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_x, r_y, r_w, r_h;
  logic              w_eol;

  assign w_eol = (r_x == r_w - CNT_W'(1));
  assign last  = w_eol && (r_y == r_h - CNT_W'(1));
  assign addr  = r_addr;
  assign x     = r_x;
  assign y     = r_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_w    <= '0;
      r_h    <= '0;
    end else if (start) begin
      r_addr <= base;
      r_x    <= '0;
      r_y    <= '0;
      r_w    <= width;
      r_h    <= height;
    end else if (adv) begin
      if (w_eol) begin
        // jump from the last pixel of this line to the first of the next
        r_x    <= '0;
        r_y    <= r_y + CNT_W'(1);
        r_addr <= r_addr + ADDR_W'(STRIDE) - ADDR_W'(r_w) + ADDR_W'(1);
      end else begin
        r_x    <= r_x + CNT_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end
endmodule

// File: rtl/maze_tile_painter.sv
// Rasterises maze-cell and clear commands into the framebuffer write port, one pixel per clock.
// Holds the command FSM, field latch, colour mux and done/err pulses.
module maze_tile_painter
  import maze_tile_painter_pkg::*;
#(
  parameter int         SCREEN_WIDTH  = maze_tile_painter_pkg::SCREEN_WIDTH,
  parameter int         SCREEN_HEIGHT = maze_tile_painter_pkg::SCREEN_HEIGHT,
  parameter int         TILE_SIZE     = maze_tile_painter_pkg::TILE_SIZE,
  parameter int         GRID_DIM      = maze_tile_painter_pkg::GRID_DIM,
  parameter logic [3:0] BORDER_COLOR  = 4'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clear,
  input  logic              cmd_border,
  input  logic [3:0]        cmd_row,
  input  logic [3:0]        cmd_col,
  input  logic [PIX_W-1:0]  cmd_color,
  output logic [ADDR_W-1:0] w_addr,
  output logic [PIX_W-1:0]  w_data,
  output logic              w_en,
  output logic              done,
  output logic              err
);
  localparam logic [CNT_W-1:0] TS    = CNT_W'(TILE_SIZE);
  localparam logic [CNT_W-1:0] TS_M1 = CNT_W'(TILE_SIZE - 1);
  localparam logic [CNT_W-1:0] SW    = CNT_W'(SCREEN_WIDTH);
  localparam logic [CNT_W-1:0] SH    = CNT_W'(SCREEN_HEIGHT);

  state_t            r_state;
  logic [PIX_W-1:0]  r_color;
  logic              r_border;
  logic [ADDR_W-1:0] w_base;
  logic [CNT_W-1:0]  w_w, w_h, w_x, w_y, w_nx, w_ny;
  logic              w_accept, w_oor, w_start, w_adv, w_last, w_eol, w_nedge;

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_oor     = (cmd_row >= 4'(GRID_DIM)) || (cmd_col >= 4'(GRID_DIM));
  assign w_start   = w_accept && (cmd_clear || !w_oor);
  assign w_base    = cmd_clear ? '0 :
                     cmul(cmd_row, TILE_SIZE * SCREEN_WIDTH) + cmul(cmd_col, TILE_SIZE);
  assign w_w       = cmd_clear ? SW : TS;
  assign w_h       = cmd_clear ? SH : TS;
  assign w_adv     = (r_state != ST_IDLE) && !w_last;

  maze_tile_addr_gen #(.STRIDE(SCREEN_WIDTH)) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .start  (w_start),
    .adv    (w_adv),
    .base   (w_base),
    .width  (w_w),
    .height (w_h),
    .addr   (w_addr),
    .x      (w_x),
    .y      (w_y),
    .last   (w_last)
  );

  // w_data is registered alongside the address, so the colour is chosen for the pixel the scan moves to next
  assign w_eol   = (w_x == TS_M1);
  assign w_nx    = w_eol ? '0 : w_x + CNT_W'(1);
  assign w_ny    = w_eol ? w_y + CNT_W'(1) : w_y;
  assign w_nedge = (w_nx == '0) || (w_ny == '0) || (w_nx == TS_M1) || (w_ny == TS_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_color  <= '0;
      r_border <= 1'b0;
      w_en     <= 1'b0;
      w_data   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          w_en <= 1'b0;
          if (w_accept) begin
            r_color  <= cmd_color;
            r_border <= cmd_border && !cmd_clear;
            if (cmd_clear) begin
              r_state <= ST_CLEAR;
              w_en    <= 1'b1;
              w_data  <= cmd_color;
            end else if (w_oor) begin
              err <= 1'b1;
            end else begin
              r_state <= ST_PAINT;
              w_en    <= 1'b1;
              w_data  <= cmd_border ? BORDER_COLOR : cmd_color;
            end
          end
        end
        ST_PAINT, ST_CLEAR: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            w_en    <= 1'b0;
            done    <= 1'b1;
          end else begin
            w_data <= (r_state == ST_PAINT && r_border && w_nedge) ? BORDER_COLOR : r_color;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maze_tile_painter.sv
// Self-checking bench: pixel streams are compared against a raster model built from plain arithmetic.
module tb_maze_tile_painter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_clear = 1'b0, cmd_border = 1'b0;
  logic [3:0]  cmd_row = '0, cmd_col = '0, cmd_color = '0;
  logic        cmd_ready, w_en, done, err;
  logic [16:0] w_addr;
  logic [3:0]  w_data;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  maze_tile_painter dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_clear(cmd_clear), .cmd_border(cmd_border), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_color(cmd_color), .w_addr(w_addr), .w_data(w_data), .w_en(w_en),
    .done(done), .err(err)
  );

  // Called at a negedge; the command is taken on the following posedge.
  task automatic issue(input bit clr, input bit brd, input int row, input int col,
                       input logic [3:0] color, input bit keep);
    cmd_clear = clr; cmd_border = brd; cmd_row = row[3:0]; cmd_col = col[3:0];
    cmd_color = color; cmd_valid = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: got cmd_ready=%b, want 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Entered at the negedge of the first write cycle; ends at the done cycle.
  task automatic run_stream(input bit clr, input bit brd, input int row, input int col,
                            input logic [3:0] color, input int stop_at, output int nbrd);
    int total, x, y, exp_a;
    logic [3:0] exp_d;
    total = clr ? 270 * 270 : 30 * 30;
    nbrd = 0;
    for (int k = 0; k < total; k++) begin
      if (clr) begin
        exp_a = k; exp_d = color;
      end else begin
        y = k / 30; x = k % 30;
        exp_a = (row * 30 + y) * 270 + col * 30 + x;
        exp_d = (brd && (x == 0 || y == 0 || x == 29 || y == 29)) ? 4'h0 : color;
      end
      if (w_en === 1'b1 && w_data === 4'h0) nbrd++;
      n_checks++;
      if ({w_en, w_addr, w_data, done, err, cmd_ready} !== {1'b1, 17'(exp_a), exp_d, 3'b000}) begin
        n_fail++;
        $display("FAIL pixel %0d: got en=%b addr=%0d data=%h done=%b err=%b rdy=%b, want en=1 addr=%0d data=%h done=0 err=0 rdy=0",
                 k, w_en, w_addr, w_data, done, err, cmd_ready, exp_a, exp_d);
      end
      if (k == stop_at) return;
      @(negedge clk);
    end
    n_checks++;
    if ({done, cmd_ready, w_en, err} !== 4'b1100) begin
      n_fail++;
      $display("FAIL done_cycle: got done=%b rdy=%b en=%b err=%b, want 1 1 0 0", done, cmd_ready, w_en, err);
    end
  endtask

  task automatic check_quiet(input string name);
    n_checks++;
    if ({w_en, done, err, cmd_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL %s: got en=%b done=%b err=%b rdy=%b, want 0 0 0 1", name, w_en, done, err, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, w_en, w_addr, w_data, done, err} !== {1'b1, 1'b0, 17'd0, 4'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b en=%b addr=%0d data=%h done=%b err=%b, want 1 0 0 0 0 0",
               cmd_ready, w_en, w_addr, w_data, done, err);
    end
    reset = 1'b0;
    @(negedge clk);
    check_quiet("after_reset");
  endtask

  task automatic test_tile_origin();
    int nb;
    issue(0, 0, 0, 0, 4'hA, 0);
    run_stream(0, 0, 0, 0, 4'hA, -1, nb);
    @(negedge clk);
    check_quiet("origin_done_pulse");
  endtask

  task automatic test_tile_corner_border();
    int nb;
    issue(0, 1, 8, 8, 4'h5, 0);
    run_stream(0, 1, 8, 8, 4'h5, -1, nb);
    n_checks++;
    if (nb !== 116) begin
      n_fail++;
      $display("FAIL border_count: got %0d, want 116", nb);
    end
    @(negedge clk);
    check_quiet("corner_done_pulse");
  endtask

  task automatic test_err();
    int nb, r, c;
    issue(0, 0, 9, 2, 4'h7, 0);
    n_checks++;
    if ({err, w_en, done, cmd_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL err_pulse: got err=%b en=%b done=%b rdy=%b, want 1 0 0 1", err, w_en, done, cmd_ready);
    end
    issue(0, 0, 3, 4, 4'hC, 0);
    run_stream(0, 0, 3, 4, 4'hC, -1, nb);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(0, 15); c = $urandom_range(9, 15);
      if (i == 1) begin r = $urandom_range(9, 15); c = $urandom_range(0, 8); end
      issue(0, $urandom_range(0, 1), r, c, 4'($urandom), 0);
      n_checks++;
      if ({err, w_en, done} !== 3'b100) begin
        n_fail++;
        $display("FAIL err_rand r=%0d c=%0d: got err=%b en=%b done=%b, want 1 0 0", r, c, err, w_en, done);
      end
      @(negedge clk);
      check_quiet("err_one_cycle");
    end
  endtask

  task automatic test_random_tiles();
    int nb, r, c;
    bit b;
    logic [3:0] col;
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, 8); c = $urandom_range(0, 8);
      b = 1'($urandom_range(0, 1)); col = 4'($urandom);
      issue(0, b, r, c, col, 0);
      run_stream(0, b, r, c, col, -1, nb);
      @(negedge clk);
    end
  endtask

  task automatic test_clear();
    int nb;
    issue(1, 0, 0, 0, 4'h3, 1);
    cmd_clear = 1'b0; cmd_row = 4'd1; cmd_col = 4'd1; cmd_color = 4'h9;
    run_stream(1, 0, 0, 0, 4'h3, -1, nb);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_quiet("clear_no_queue");
  endtask

  task automatic test_reset_mid();
    int nb;
    issue(0, 1, 2, 3, 4'h7, 0);
    run_stream(0, 1, 2, 3, 4'h7, 449, nb);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, w_en, w_addr, w_data, done, err} !== {1'b1, 1'b0, 17'd0, 4'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy=%b en=%b addr=%0d data=%h done=%b err=%b, want 1 0 0 0 0 0",
               cmd_ready, w_en, w_addr, w_data, done, err);
    end
    reset = 1'b0;
    @(negedge clk);
    check_quiet("reset_mid_idle");
    issue(0, 0, 4, 6, 4'hE, 0);
    run_stream(0, 0, 4, 6, 4'hE, -1, nb);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int nb;
    issue(0, 0, 1, 2, 4'h6, 1);
    cmd_clear = 1'b0; cmd_border = 1'b1; cmd_row = 4'd7; cmd_col = 4'd0; cmd_color = 4'hB;
    run_stream(0, 0, 1, 2, 4'h6, -1, nb);
    @(negedge clk);
    cmd_valid = 1'b0;
    run_stream(0, 1, 7, 0, 4'hB, -1, nb);
    @(negedge clk);
    check_quiet("b2b_end");
  endtask

  initial begin
    test_reset();
    test_tile_origin();
    test_tile_corner_border();
    test_err();
    test_random_tiles();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
